// File: rtl/ddr_req_sched.sv
// Three-channel DDR request scheduler: store > load > PC with PC anti-starvation.
// One transaction in flight, IDLE -> ISSUE -> WAIT, registered completion pulses.
module ddr_req_sched #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         pc_index_valid,
  input  logic [18:0]  pc_index,
  output logic         pc_index_ready,
  output logic [511:0] pc_read_inst,
  output logic         pc_operation_done,
  input  logic         opstore_index_valid,
  input  logic [18:0]  opstore_index,
  output logic         opstore_index_ready,
  input  logic [63:0]  opstore_write_mask,
  input  logic [63:0]  opstore_write_data,
  output logic         opstore_operation_done,
  input  logic         opload_index_valid,
  input  logic [18:0]  opload_index,
  output logic         opload_index_ready,
  output logic [63:0]  opload_read_data,
  output logic         opload_operation_done,
  output logic         ddr_chip_enable,
  output logic [18:0]  ddr_index,
  output logic         ddr_write_enable,
  output logic         ddr_burst_mode,
  output logic [63:0]  ddr_write_mask,
  output logic [63:0]  ddr_write_data,
  input  logic [63:0]  ddr_opload_read_data,
  input  logic [511:0] ddr_pc_read_inst,
  input  logic         ddr_operation_done,
  input  logic         ddr_ready
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    CH_NONE,
    CH_PC,
    CH_ST,
    CH_LD
  } ch_t;

  state_t      state;
  state_t      state_nxt;
  ch_t         ch;
  logic [3:0]  pc_wait_cnt;
  logic        idle;
  logic        pc_force;
  logic        sel_pc;
  logic        sel_st;
  logic        sel_ld;
  logic        grant;
  logic        wait_done;
  logic [18:0] idx_nxt;

  // Readies are gated by reset so nothing is granted while reset is held.
  always_comb begin
    idle     = (state == IDLE) && reset_n;
    pc_force = pc_index_valid && (pc_wait_cnt >= LIMIT);
    sel_st   = idle && opstore_index_valid && !pc_force;
    sel_ld   = idle && opload_index_valid
               && !opstore_index_valid && !pc_force;
    sel_pc   = idle && pc_index_valid
               && (pc_force
                   || !(opstore_index_valid || opload_index_valid));
    grant    = sel_pc || sel_st || sel_ld;
  end

  always_comb begin
    idx_nxt = pc_index;
    unique case (1'b1)
      sel_st:  idx_nxt = opstore_index;
      sel_ld:  idx_nxt = opload_index;
      default: idx_nxt = pc_index;
    endcase
  end

  assign wait_done = (state == WAIT) && ddr_operation_done;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   if (ddr_ready) state_nxt = WAIT;
      WAIT:    if (ddr_operation_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  assign pc_index_ready      = sel_pc;
  assign opstore_index_ready = sel_st;
  assign opload_index_ready  = sel_ld;
  assign ddr_chip_enable     = (state == ISSUE) && ddr_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ch               <= CH_NONE;
      ddr_index        <= '0;
      ddr_write_enable <= 1'b0;
      ddr_burst_mode   <= 1'b0;
      ddr_write_mask   <= '0;
      ddr_write_data   <= '0;
    end else if (grant) begin
      ch               <= sel_st ? CH_ST : (sel_ld ? CH_LD : CH_PC);
      ddr_index        <= idx_nxt;
      ddr_write_enable <= sel_st;
      ddr_burst_mode   <= sel_pc;
      ddr_write_mask   <= sel_st ? opstore_write_mask : '0;
      ddr_write_data   <= sel_st ? opstore_write_data : '0;
    end
  end

  // Counter only advances on grant cycles; any cycle without PC valid clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_wait_cnt <= '0;
    end else if (!pc_index_valid || sel_pc) begin
      pc_wait_cnt <= '0;
    end else if (grant && (pc_wait_cnt != 4'hf)) begin
      pc_wait_cnt <= pc_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_operation_done      <= 1'b0;
      opstore_operation_done <= 1'b0;
      opload_operation_done  <= 1'b0;
      pc_read_inst           <= '0;
      opload_read_data       <= '0;
    end else begin
      pc_operation_done      <= wait_done && (ch == CH_PC);
      opstore_operation_done <= wait_done && (ch == CH_ST);
      opload_operation_done  <= wait_done && (ch == CH_LD);
      if (wait_done && (ch == CH_PC)) pc_read_inst <= ddr_pc_read_inst;
      if (wait_done && (ch == CH_LD)) opload_read_data <= ddr_opload_read_data;
    end
  end

endmodule

// File: tb/tb_ddr_req_sched.sv
// Bench for ddr_req_sched: transaction-level model, random traffic,
// plus directed scenarios with literal expectations.
module tb_ddr_req_sched;

  localparam int LIM = 2;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         pc_index_valid;
  logic [18:0]  pc_index;
  logic         pc_index_ready;
  logic [511:0] pc_read_inst;
  logic         pc_operation_done;
  logic         opstore_index_valid;
  logic [18:0]  opstore_index;
  logic         opstore_index_ready;
  logic [63:0]  opstore_write_mask;
  logic [63:0]  opstore_write_data;
  logic         opstore_operation_done;
  logic         opload_index_valid;
  logic [18:0]  opload_index;
  logic         opload_index_ready;
  logic [63:0]  opload_read_data;
  logic         opload_operation_done;
  logic         ddr_chip_enable;
  logic [18:0]  ddr_index;
  logic         ddr_write_enable;
  logic         ddr_burst_mode;
  logic [63:0]  ddr_write_mask;
  logic [63:0]  ddr_write_data;
  logic [63:0]  ddr_opload_read_data;
  logic [511:0] ddr_pc_read_inst;
  logic         ddr_operation_done;
  logic         ddr_ready;

  ddr_req_sched #(.STARVE_LIMIT(LIM)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .pc_index_valid(pc_index_valid),
    .pc_index(pc_index),
    .pc_index_ready(pc_index_ready),
    .pc_read_inst(pc_read_inst),
    .pc_operation_done(pc_operation_done),
    .opstore_index_valid(opstore_index_valid),
    .opstore_index(opstore_index),
    .opstore_index_ready(opstore_index_ready),
    .opstore_write_mask(opstore_write_mask),
    .opstore_write_data(opstore_write_data),
    .opstore_operation_done(opstore_operation_done),
    .opload_index_valid(opload_index_valid),
    .opload_index(opload_index),
    .opload_index_ready(opload_index_ready),
    .opload_read_data(opload_read_data),
    .opload_operation_done(opload_operation_done),
    .ddr_chip_enable(ddr_chip_enable),
    .ddr_index(ddr_index),
    .ddr_write_enable(ddr_write_enable),
    .ddr_burst_mode(ddr_burst_mode),
    .ddr_write_mask(ddr_write_mask),
    .ddr_write_data(ddr_write_data),
    .ddr_opload_read_data(ddr_opload_read_data),
    .ddr_pc_read_inst(ddr_pc_read_inst),
    .ddr_operation_done(ddr_operation_done),
    .ddr_ready(ddr_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: the single outstanding transaction as a record plus channel results.
  bit           m_busy;
  bit           m_issued;
  int           m_ch;
  logic [18:0]  m_idx;
  bit           m_we;
  bit           m_burst;
  logic [63:0]  m_mask;
  logic [63:0]  m_data;
  logic [511:0] m_pc;
  logic [63:0]  m_ld;
  int           m_done;
  int           m_wait;

  task automatic chk(input string nm, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_ch = 0;
    m_idx = '0; m_we = 0; m_burst = 0;
    m_mask = '0; m_data = '0;
    m_pc = '0; m_ld = '0;
    m_done = 0; m_wait = 0;
  endtask

  // 1 = PC, 2 = store, 3 = load, 0 = no grant this cycle.
  function automatic int winner();
    if (!reset_n || m_busy) return 0;
    if (pc_index_valid && m_wait >= LIM) return 1;
    if (opstore_index_valid) return 2;
    if (opload_index_valid) return 3;
    if (pc_index_valid) return 1;
    return 0;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic settle();
    int w;
    #1;
    w = winner();
    chk("pc_ready", pc_index_ready, w == 1);
    chk("st_ready", opstore_index_ready, w == 2);
    chk("ld_ready", opload_index_ready, w == 3);
    chk("chip_en", ddr_chip_enable,
        reset_n && m_busy && !m_issued && ddr_ready);
    chk("pc_done", pc_operation_done, m_done == 1);
    chk("st_done", opstore_operation_done, m_done == 2);
    chk("ld_done", opload_operation_done, m_done == 3);
    chk("pc_data", pc_read_inst, m_pc);
    chk("ld_data", opload_read_data, m_ld);
    chk("ddr_idx", ddr_index, m_idx);
    chk("ddr_we", ddr_write_enable, m_we);
    chk("ddr_burst", ddr_burst_mode, m_burst);
    chk("ddr_mask", ddr_write_mask, m_mask);
    chk("ddr_data", ddr_write_data, m_data);
  endtask

  task automatic advance();
    int w;
    if (!reset_n) begin
      model_reset();
    end else begin
      w = winner();
      m_done = 0;
      if (w != 0) begin
        m_busy = 1; m_issued = 0; m_ch = w;
        m_we = (w == 2); m_burst = (w == 1);
        m_idx = (w == 2) ? opstore_index :
                (w == 3) ? opload_index : pc_index;
        m_mask = (w == 2) ? opstore_write_mask : '0;
        m_data = (w == 2) ? opstore_write_data : '0;
      end else if (m_busy && !m_issued) begin
        if (ddr_ready) m_issued = 1;
      end else if (m_busy && ddr_operation_done) begin
        m_done = m_ch;
        if (m_ch == 1) m_pc = ddr_pc_read_inst;
        if (m_ch == 3) m_ld = ddr_opload_read_data;
        m_busy = 0;
      end
      if (!pc_index_valid || w == 1) m_wait = 0;
      else if (w != 0) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
    end
    @(negedge clock);
  endtask

  task automatic zero_inputs();
    pc_index_valid = 0; pc_index = '0;
    opstore_index_valid = 0; opstore_index = '0;
    opstore_write_mask = '0; opstore_write_data = '0;
    opload_index_valid = 0; opload_index = '0;
    ddr_opload_read_data = '0; ddr_pc_read_inst = '0;
    ddr_operation_done = 0; ddr_ready = 0;
  endtask

  task automatic drain();
    zero_inputs();
    ddr_ready = 1; ddr_operation_done = 1;
    for (int i = 0; i < 5; i++) begin settle(); advance(); end
    zero_inputs();
  endtask

  function automatic int seen_grant();
    if (opstore_index_ready) return 2;
    if (opload_index_ready) return 3;
    if (pc_index_valid && pc_index_ready) return 1;
    return 0;
  endfunction

  initial begin
    int got[$];
    int dn[4];
    int g;
    int e41[3];
    int e42[6];
    logic [511:0] ones;
    e41 = '{2, 3, 1};
    e42 = '{2, 2, 1, 2, 2, 1};
    ones = '1;
    zero_inputs();
    model_reset();
    @(negedge clock);
    settle();
    chk("rst_pc_data", pc_read_inst, 0);
    chk("rst_idx", ddr_index, 0);
    advance();
    reset_n = 1;

    // Single store, fixed latency
    opstore_index_valid = 1; opstore_index = 19'h12345;
    opstore_write_mask = 64'hff00; opstore_write_data = 64'hdeadbeef;
    ddr_ready = 1;
    settle();
    chk("s40_ready_c0", opstore_index_ready, 1);
    advance();
    opstore_index_valid = 0;
    settle();
    chk("s40_ce_c1", ddr_chip_enable, 1);
    chk("s40_we_c1", ddr_write_enable, 1);
    chk("s40_idx_c1", ddr_index, 19'h12345);
    advance();
    settle(); advance();
    settle(); advance();
    ddr_operation_done = 1;
    settle();
    chk("s40_done_c4", opstore_operation_done, 0);
    advance();
    ddr_operation_done = 0;
    settle();
    chk("s40_done_c5", opstore_operation_done, 1);
    advance();
    settle();
    chk("s40_done_c6", opstore_operation_done, 0);
    advance();

    // All three requesters together
    drain();
    pc_index_valid = 1; opstore_index_valid = 1; opload_index_valid = 1;
    pc_index = 19'h1; opstore_index = 19'h2; opload_index = 19'h3;
    ddr_ready = 1; ddr_operation_done = 1;
    ddr_opload_read_data = 64'h0123456789abcdef;
    ddr_pc_read_inst = rand512();
    dn = '{0, 0, 0, 0};
    got.delete();
    for (int c = 0; c < 40 && got.size() < 3; c++) begin
      settle();
      g = seen_grant();
      if (g != 0) got.push_back(g);
      dn[1] += int'(pc_operation_done);
      dn[2] += int'(opstore_operation_done);
      dn[3] += int'(opload_operation_done);
      advance();
      if (g == 1) pc_index_valid = 0;
      if (g == 2) opstore_index_valid = 0;
      if (g == 3) opload_index_valid = 0;
    end
    for (int c = 0; c < 4; c++) begin
      settle();
      dn[1] += int'(pc_operation_done);
      dn[2] += int'(opstore_operation_done);
      dn[3] += int'(opload_operation_done);
      advance();
    end
    chk("o41_count", got.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("o41_grant%0d", i), got.size() > i ? got[i] : -1, e41[i]);
    chk("o41_pc_pulses", dn[1], 1);
    chk("o41_st_pulses", dn[2], 1);
    chk("o41_ld_pulses", dn[3], 1);
    chk("o41_ld_data", opload_read_data, 64'h0123456789abcdef);

    // Starvation: PC and store held valid
    drain();
    pc_index_valid = 1; opstore_index_valid = 1;
    ddr_ready = 1; ddr_operation_done = 1;
    got.delete();
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      settle();
      g = seen_grant();
      if (g != 0) got.push_back(g);
      advance();
    end
    chk("s42_count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("s42_grant%0d", i), got.size() > i ? got[i] : -1, e42[i]);

    // PC burst with ISSUE held off
    drain();
    pc_index_valid = 1; pc_index = 19'h7abcd;
    settle();
    chk("p43_ready", pc_index_ready, 1);
    advance();
    pc_index_valid = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("p43_ce_hold%0d", i), ddr_chip_enable, 0);
      chk($sformatf("p43_burst%0d", i), ddr_burst_mode, 1);
      advance();
    end
    ddr_ready = 1;
    settle();
    chk("p43_ce_go", ddr_chip_enable, 1);
    advance();
    ddr_ready = 0;
    ddr_pc_read_inst = ones; ddr_operation_done = 1;
    settle();
    chk("p43_burst_wait", ddr_burst_mode, 1);
    chk("p43_ce_wait", ddr_chip_enable, 0);
    advance();
    ddr_operation_done = 0; ddr_pc_read_inst = '0;
    settle();
    chk("p43_done", pc_operation_done, 1);
    chk("p43_data", pc_read_inst, ones);
    advance();

    // Reset while WAIT
    drain();
    pc_index_valid = 1; pc_index = 19'h55; ddr_ready = 1;
    settle(); advance();
    pc_index_valid = 0;
    settle(); advance();
    settle(); advance();
    reset_n = 0;
    model_reset();
    settle();
    chk("r44_burst", ddr_burst_mode, 0);
    chk("r44_idx", ddr_index, 0);
    chk("r44_pc_data", pc_read_inst, 0);
    advance();
    reset_n = 1;
    ddr_operation_done = 1; ddr_pc_read_inst = ones;
    settle(); advance();
    ddr_operation_done = 0;
    settle();
    chk("r44_no_done", pc_operation_done, 0);
    advance();

    // Random traffic
    drain();
    for (int c = 0; c < 2500; c++) begin
      pc_index_valid = $urandom_range(0, 2) != 0;
      opstore_index_valid = $urandom_range(0, 2) == 0;
      opload_index_valid = $urandom_range(0, 2) == 0;
      pc_index = 19'($urandom);
      opstore_index = 19'($urandom);
      opload_index = 19'($urandom);
      opstore_write_mask = {$urandom, $urandom};
      opstore_write_data = {$urandom, $urandom};
      ddr_opload_read_data = {$urandom, $urandom};
      ddr_pc_read_inst = rand512();
      ddr_ready = $urandom_range(0, 3) != 0;
      ddr_operation_done = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 0;
        model_reset();
      end
      settle();
      advance();
      reset_n = 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_req_sched.md
DDR_REQ_SCHED -- requirements
Module: ddr_req_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive non-PC grants while PC waits before PC is forced to win (range 1..15).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port pc_index_valid  input  1  PC burst-read request.
REQ-005 SHALL have port pc_index  input  19  PC burst-read index.
REQ-006 SHALL have port pc_index_ready  output  1  PC request accepted this cycle.
REQ-007 SHALL have port pc_read_inst  output  512  registered burst-read data.
REQ-008 SHALL have port pc_operation_done  output  1  one-cycle PC completion pulse.
REQ-009 SHALL have port opstore_index_valid  input  1  store request.
REQ-010 SHALL have port opstore_index  input  19  store index.
REQ-011 SHALL have port opstore_index_ready  output  1  store request accepted this cycle.
REQ-012 SHALL have port opstore_write_mask  input  64  store byte/bit mask.
REQ-013 SHALL have port opstore_write_data  input  64  store data.
REQ-014 SHALL have port opstore_operation_done  output  1  one-cycle store completion pulse.
REQ-015 SHALL have port opload_index_valid  input  1  load request.
REQ-016 SHALL have port opload_index  input  19  load index.
REQ-017 SHALL have port opload_index_ready  output  1  load request accepted this cycle.
REQ-018 SHALL have port opload_read_data  output  64  registered load data.
REQ-019 SHALL have port opload_operation_done  output  1  one-cycle load completion pulse.
REQ-020 SHALL have port ddr_chip_enable  output  1  one-cycle command strobe to DDR.
REQ-021 SHALL have port ddr_index  output  19  latched command index.
REQ-022 SHALL have port ddr_write_enable  output  1  1 = write command.
REQ-023 SHALL have port ddr_burst_mode  output  1  1 = 512-bit burst read.
REQ-024 SHALL have port ddr_write_mask  output  64  latched store mask, 0 otherwise.
REQ-025 SHALL have port ddr_write_data  output  64  latched store data, 0 otherwise.
REQ-026 SHALL have port ddr_opload_read_data  input  64  DDR single read data.
REQ-027 SHALL have port ddr_pc_read_inst  input  512  DDR burst read data.
REQ-028 SHALL have port ddr_operation_done  input  1  DDR completion, valid in WAIT only.
REQ-029 SHALL have port ddr_ready  input  1  DDR can accept a command.

Function
REQ-030 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, exactly one transaction outstanding.
REQ-031 IDLE: SHALL select one valid requester, assert only its *_index_ready combinationally that cycle, latch index, write, burst, mask, data and grant id at the edge, go to ISSUE; no valid -> stay IDLE, all readies 0.
REQ-032 Priority SHALL be store > load > PC, except PC wins when pc_wait_cnt >= STARVE_LIMIT.
REQ-033 pc_wait_cnt (4-bit, saturating at 15) SHALL increment on each non-PC grant while pc_index_valid=1, clear on PC grant or when pc_index_valid=0.
REQ-034 ISSUE: ddr_ready=1 -> ddr_chip_enable=1 for exactly that cycle, go WAIT; ddr_ready=0 -> hold ISSUE, chip_enable 0.
REQ-035 ddr_index/write_enable/burst_mode/write_mask/write_data SHALL remain stable from ISSUE through WAIT; mask/data 0 for non-store.
REQ-036 WAIT: on edge with ddr_operation_done=1 SHALL register the granted channel's read data (PC: ddr_pc_read_inst, load: ddr_opload_read_data), pulse only that channel's *_operation_done the following cycle, return to IDLE.
REQ-037 pc_read_inst/opload_read_data SHALL hold until that channel's next completion; ddr_operation_done in IDLE/ISSUE SHALL be ignored.
REQ-038 A new grant MAY occur in the same cycle the previous done pulse is visible (back-to-back, 1 idle cycle minimum).

Reset
REQ-039 reset_n=0 SHALL immediately force IDLE, pc_wait_cnt=0 and every output to 0, dropping any in-flight transaction and its done pulse.

Verification
REQ-040 Store valid at cycle 0, ddr_ready=1, ddr_operation_done at cycle 4 -> opstore_index_ready cycle 0, chip_enable+write_enable cycle 1, opstore_operation_done cycle 5 only.
REQ-041 Store, load, PC valid together -> grant order store, load, PC; each done pulse only on its own channel.
REQ-042 PC and store continuously valid, STARVE_LIMIT=2 -> grants store, store, PC, store, store, PC.
REQ-043 PC granted, ddr_ready=0 for 3 cycles -> ISSUE held, chip_enable asserted once on 4th cycle; ddr_pc_read_inst=all-ones at done -> pc_read_inst=all-ones, burst_mode=1 throughout.
REQ-044 reset_n low during WAIT -> outputs 0 asynchronously, later ddr_operation_done produces no done pulse.
